// File: rtl/keypad_encoder.sv
// Keypad and start/stop button front end: synchronises and debounces raw inputs,
// turns a stable single key into a one-cycle BCD/one-hot strobe and the buttons into press pulses.
module keypad_encoder #(
  parameter int DB_CYCLES = 3
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [9:0] keypad_raw,
  input  logic       startn_raw,
  input  logic       stopn_raw,
  output logic [3:0] digit,
  output logic       digit_valid,
  output logic [9:0] keypad,
  output logic       start_pulse,
  output logic       stop_pulse
);

  localparam logic [3:0] DB_W = 4'(DB_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_HELD,
    S_REL
  } key_state_t;

  logic [9:0] r_kp_s1;
  logic [9:0] r_kp_s2;

  key_state_t r_state;
  key_state_t w_state_next;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_next;
  logic [3:0] w_cnt_inc;
  logic [3:0] r_cand;
  logic [3:0] w_cand_next;
  logic [3:0] r_digit;
  logic [3:0] w_digit_next;
  logic       r_valid;
  logic       w_valid_next;

  logic [3:0] w_kp_count;
  logic [3:0] w_kp_idx;
  logic       w_kp_none;
  logic       w_kp_key;

  logic [1:0] w_btn_n_raw;
  logic [1:0] w_btn_rise;
  logic       r_start_pulse;
  logic       r_stop_pulse;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_kp_s1 <= '0;
      r_kp_s2 <= '0;
    end else begin
      r_kp_s1 <= keypad_raw;
      r_kp_s2 <= r_kp_s1;
    end
  end

  // Classify the synchronised lines: none, exactly one key (with its index), or several.
  always_comb begin
    w_kp_count = '0;
    w_kp_idx   = '0;
    for (int i = 0; i < 10; i++) begin
      w_kp_count = w_kp_count + {3'b000, r_kp_s2[i]};
      if (r_kp_s2[i]) begin
        w_kp_idx = 4'(i);
      end
    end
  end

  assign w_kp_none = (w_kp_count == 4'd0);
  assign w_kp_key  = (w_kp_count == 4'd1);
  assign w_cnt_inc = (r_cnt >= DB_W) ? DB_W : r_cnt + 4'd1;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cand  <= '0;
      r_digit <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_cand  <= w_cand_next;
      r_digit <= w_digit_next;
      r_valid <= w_valid_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_cand_next  = r_cand;
    w_digit_next = r_digit;
    w_valid_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_kp_key) begin
          w_state_next = S_ARM;
          w_cand_next  = w_kp_idx;
          w_cnt_next   = 4'd1;
        end
      end
      S_ARM: begin
        if (w_kp_key && (w_kp_idx == r_cand)) begin
          if (w_cnt_inc >= DB_W) begin
            w_state_next = S_HELD;
            w_digit_next = r_cand;
            w_valid_next = 1'b1;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end else if (w_kp_key) begin
          w_cand_next = w_kp_idx;
          w_cnt_next  = 4'd1;
        end else begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end
      end
      S_HELD: begin
        if (w_kp_none) begin
          w_state_next = S_REL;
          w_cnt_next   = 4'd1;
        end
      end
      S_REL: begin
        // Any activity during release is bounce: go back to HELD so no second strobe can occur.
        if (w_kp_none) begin
          if (w_cnt_inc >= DB_W) begin
            w_state_next = S_IDLE;
            w_cnt_next   = '0;
          end else begin
            w_cnt_next = w_cnt_inc;
          end
        end else begin
          w_state_next = S_HELD;
          w_cnt_next   = '0;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign w_btn_n_raw = {stopn_raw, startn_raw};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic       r_s1;
    logic       r_s2;
    logic       r_lvl;
    logic [3:0] r_bcnt;
    logic [3:0] w_binc;
    logic       w_pressed;
    logic       w_differs;

    assign w_pressed      = ~r_s2;
    assign w_differs      = (w_pressed != r_lvl);
    assign w_binc         = (r_bcnt >= DB_W) ? DB_W : r_bcnt + 4'd1;
    assign w_btn_rise[gi] = w_differs & w_pressed & (w_binc >= DB_W);

    always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
        r_s1   <= 1'b1;
        r_s2   <= 1'b1;
        r_lvl  <= 1'b0;
        r_bcnt <= '0;
      end else begin
        r_s1 <= w_btn_n_raw[gi];
        r_s2 <= r_s1;
        if (w_differs) begin
          if (w_binc >= DB_W) begin
            r_lvl  <= w_pressed;
            r_bcnt <= '0;
          end else begin
            r_bcnt <= w_binc;
          end
        end else begin
          r_bcnt <= '0;
        end
      end
    end
  end

  // Stop wins a same-cycle tie; start's level still flips, so that press is consumed.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      r_start_pulse <= 1'b0;
      r_stop_pulse  <= 1'b0;
    end else begin
      r_start_pulse <= w_btn_rise[0] & ~w_btn_rise[1];
      r_stop_pulse  <= w_btn_rise[1];
    end
  end

  for (genvar gi = 0; gi < 10; gi++) begin : g_onehot
    assign keypad[gi] = r_valid & (r_digit == 4'(gi));
  end

  assign digit       = r_digit;
  assign digit_valid = r_valid;
  assign start_pulse = r_start_pulse;
  assign stop_pulse  = r_stop_pulse;

endmodule

// File: tb/tb_keypad_encoder.sv
// Cycle-by-cycle vector bench for keypad_encoder: each row drives raw inputs for one
// clock and compares all outputs after that edge against hand-derived expectations.
module tb_keypad_encoder;

  logic       clk = 1'b0;
  logic       clear;
  logic [9:0] keypad_raw;
  logic       startn_raw;
  logic       stopn_raw;
  logic [3:0] digit;
  logic       digit_valid;
  logic [9:0] keypad;
  logic       start_pulse;
  logic       stop_pulse;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int         tag;
    logic [9:0] kp;
    logic       sn;
    logic       tn;
    logic       clr;
    logic       ev;
    logic [3:0] ed;
    logic [9:0] ek;
    logic       es;
    logic       et;
  } vec_t;

  vec_t vecs[$];

  keypad_encoder #(.DB_CYCLES(3)) dut (
    .clk         (clk),
    .clear       (clear),
    .keypad_raw  (keypad_raw),
    .startn_raw  (startn_raw),
    .stopn_raw   (stopn_raw),
    .digit       (digit),
    .digit_valid (digit_valid),
    .keypad      (keypad),
    .start_pulse (start_pulse),
    .stop_pulse  (stop_pulse)
  );

  always #5 clk = ~clk;

  function automatic void add(input int tag, input logic [9:0] kp, input logic sn,
                              input logic tn, input logic clr, input logic ev,
                              input logic [3:0] ed, input logic [9:0] ek,
                              input logic es, input logic et);
    vec_t v;
    v.tag = tag; v.kp = kp; v.sn = sn; v.tn = tn; v.clr = clr;
    v.ev = ev; v.ed = ed; v.ek = ek; v.es = es; v.et = et;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int idx, input logic ev, input logic [3:0] ed,
                       input logic [9:0] ek, input logic es, input logic et);
    logic [16:0] act;
    logic [16:0] req;
    act = {digit_valid, digit, keypad, start_pulse, stop_pulse};
    req = {ev, ed, ek, es, et};
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s #%0d: got valid=%b digit=%0d keypad=%b start=%b stop=%b, want valid=%b digit=%0d keypad=%b start=%b stop=%b",
               name, idx, digit_valid, digit, keypad, start_pulse, stop_pulse, ev, ed, ek, es, et);
    end else begin
      $display("vec %s #%0d: valid=%b digit=%0d keypad=%b start=%b stop=%b",
               name, idx, digit_valid, digit, keypad, start_pulse, stop_pulse);
    end
  endtask

  initial begin
    clear      = 1'b1;
    keypad_raw = '0;
    startn_raw = 1'b1;
    stopn_raw  = 1'b1;

    // A: single key 1 held ten cycles, then released
    for (int i = 1; i <= 10; i++)
      add(1, 10'h002, 1, 1, 0, i == 5, (i >= 5) ? 4'd1 : 4'd0, (i == 5) ? 10'h002 : 10'h000, 0, 0);
    for (int i = 1; i <= 6; i++) add(1, 10'h000, 1, 1, 0, 0, 4'd1, 10'h000, 0, 0);
    // B: key 7 toggling for six cycles, then held
    for (int i = 1; i <= 6; i++)
      add(2, (i % 2 == 1) ? 10'h080 : 10'h000, 1, 1, 0, 0, 4'd1, 10'h000, 0, 0);
    for (int i = 1; i <= 8; i++)
      add(2, 10'h080, 1, 1, 0, i == 5, (i >= 5) ? 4'd7 : 4'd1, (i == 5) ? 10'h080 : 10'h000, 0, 0);
    for (int i = 1; i <= 6; i++) add(2, 10'h000, 1, 1, 0, 0, 4'd7, 10'h000, 0, 0);
    // C: two keys together are ignored, then key 2 alone
    for (int i = 1; i <= 20; i++) add(3, 10'h005, 1, 1, 0, 0, 4'd7, 10'h000, 0, 0);
    for (int i = 1; i <= 7; i++)
      add(3, 10'h004, 1, 1, 0, i == 5, (i >= 5) ? 4'd2 : 4'd7, (i == 5) ? 10'h004 : 10'h000, 0, 0);
    for (int i = 1; i <= 6; i++) add(3, 10'h000, 1, 1, 0, 0, 4'd2, 10'h000, 0, 0);
    // D: key 4 with a one-cycle bounce on release
    for (int i = 1; i <= 7; i++)
      add(4, 10'h010, 1, 1, 0, i == 5, (i >= 5) ? 4'd4 : 4'd2, (i == 5) ? 10'h010 : 10'h000, 0, 0);
    add(4, 10'h000, 1, 1, 0, 0, 4'd4, 10'h000, 0, 0);
    add(4, 10'h010, 1, 1, 0, 0, 4'd4, 10'h000, 0, 0);
    for (int i = 1; i <= 8; i++) add(4, 10'h000, 1, 1, 0, 0, 4'd4, 10'h000, 0, 0);
    // E: start and stop pressed together, start released and re-pressed
    for (int i = 1; i <= 8; i++) add(5, 10'h000, 0, 0, 0, 0, 4'd4, 10'h000, 0, i == 5);
    for (int i = 1; i <= 6; i++) add(5, 10'h000, 1, 0, 0, 0, 4'd4, 10'h000, 0, 0);
    for (int i = 1; i <= 7; i++) add(5, 10'h000, 0, 0, 0, 0, 4'd4, 10'h000, i == 5, 0);
    for (int i = 1; i <= 6; i++) add(5, 10'h000, 1, 1, 0, 0, 4'd4, 10'h000, 0, 0);
    // F: key 3 and stop accepted in the same cycle
    for (int i = 1; i <= 7; i++)
      add(6, 10'h008, 1, 0, 0, i == 5, (i >= 5) ? 4'd3 : 4'd4, (i == 5) ? 10'h008 : 10'h000, 0, i == 5);
    for (int i = 1; i <= 6; i++) add(6, 10'h000, 1, 1, 0, 0, 4'd3, 10'h000, 0, 0);
    // G: clear two cycles into ARM with key 9 held, key accepted afresh afterwards
    for (int i = 1; i <= 4; i++) add(7, 10'h200, 1, 1, 0, 0, 4'd3, 10'h000, 0, 0);
    add(7, 10'h200, 1, 1, 1, 0, 4'd0, 10'h000, 0, 0);
    for (int i = 1; i <= 8; i++)
      add(7, 10'h200, 1, 1, 0, i == 5, (i >= 5) ? 4'd9 : 4'd0, (i == 5) ? 10'h200 : 10'h000, 0, 0);
    for (int i = 1; i <= 6; i++) add(7, 10'h000, 1, 1, 0, 0, 4'd9, 10'h000, 0, 0);

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    check("reset", 0, 0, 4'd0, 10'h000, 0, 0);
    clear = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      keypad_raw = vecs[i].kp;
      startn_raw = vecs[i].sn;
      stopn_raw  = vecs[i].tn;
      clear      = vecs[i].clr;
      @(posedge clk); #1;
      check($sformatf("seq%0d", vecs[i].tag), i, vecs[i].ev, vecs[i].ed, vecs[i].ek,
            vecs[i].es, vecs[i].et);
    end
    clear = 1'b0;

    // Clear must drop the outputs at once, without waiting for a clock edge
    keypad_raw = 10'h020;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
    end
    check("key5_strobe", 0, 1, 4'd5, 10'h020, 0, 0);
    clear = 1'b1;
    #1;
    check("async_clear", 0, 0, 4'd0, 10'h000, 0, 0);
    @(posedge clk); #1;
    clear      = 1'b0;
    keypad_raw = '0;
    @(posedge clk); #1;
    check("after_clear", 0, 0, 4'd0, 10'h000, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
